// File: rtl/muldiv_unit_ctrl.sv
// muldiv_unit_ctrl: iterative 32-step multiply/divide sequencer for execute.
// Optional divider datapath is compiled only when MULDIV_DIV_EN is defined.
module muldiv_unit_ctrl (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [63:0] result,
    output logic        done,
    output logic        busy,
    output logic        stall
);

    localparam int         ITER = 32;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_p_q, sgn_p_d;
    logic [63:0] res_q, res_d;

    logic        sgn_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [63:0] mul_fix;

`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        sgn_r_q, sgn_r_d;
    logic [33:0] trial;
    logic [63:0] div_nxt;
    logic [63:0] div_fix;
`endif

    assign sgn_op = ~op[0];
    assign a_mag  = (sgn_op && a[31]) ? -a : a;
    assign b_mag  = (sgn_op && b[31]) ? -b : b;

    // Multiplier LSB sits in acc[0]; add multiplicand into the high half, then shift.
    assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    assign mul_nxt = {mul_sum, acc_q[31:1]};
    assign mul_fix = sgn_p_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    // acc holds {remainder, dividend/quotient}; shift left and trial-subtract.
    assign trial   = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
    assign div_nxt = trial[33] ? {acc_q[62:0], 1'b0}
                               : {trial[31:0], acc_q[30:0], 1'b1};
    assign div_fix = {(sgn_r_q ? -acc_q[63:32] : acc_q[63:32]),
                      (sgn_p_q ? -acc_q[31:0]  : acc_q[31:0])};
`endif

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        sgn_p_d = sgn_p_q;
        res_d   = res_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        sgn_r_d  = sgn_r_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!flush && req) begin
                    cnt_d   = '0;
                    sgn_p_d = sgn_op & (a[31] ^ b[31]);
                    if (!op[1]) begin
                        opnd_d  = a_mag;
                        acc_d   = {32'd0, b_mag};
                        state_d = CALC;
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b0;
`endif
                    end else begin
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b1;
                        opnd_d   = b_mag;
                        sgn_r_d  = sgn_op & a[31];
                        if (b == 32'd0) begin
                            acc_d   = {a, 32'hFFFF_FFFF};
                            sgn_p_d = 1'b0;
                            sgn_r_d = 1'b0;
                            state_d = FIX;
                        end else begin
                            acc_d   = {32'd0, a_mag};
                            state_d = CALC;
                        end
`else
                        res_d   = '0;
                        state_d = DONE;
`endif
                    end
                end
            end
            CALC: begin
                if (flush || !req) begin
                    state_d = IDLE;
                end else begin
`ifdef MULDIV_DIV_EN
                    acc_d = is_div_q ? div_nxt : mul_nxt;
`else
                    acc_d = mul_nxt;
`endif
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush || !req) begin
                    state_d = IDLE;
                end else begin
`ifdef MULDIV_DIV_EN
                    res_d = is_div_q ? div_fix : mul_fix;
`else
                    res_d = mul_fix;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            sgn_p_q <= 1'b0;
            res_q   <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            sgn_r_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            sgn_p_q <= sgn_p_d;
            res_q   <= res_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            sgn_r_q  <= sgn_r_d;
`endif
        end
    end

    assign result = res_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);
    assign stall  = req && !done;

endmodule

// File: tb/tb_muldiv_unit_ctrl.sv
// tb_muldiv_unit_ctrl: randomized and directed checks against an arithmetic model.
// Divide expectations follow MULDIV_DIV_EN as seen by this compile.
module tb_muldiv_unit_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [63:0] result;
    logic        done;
    logic        busy;
    logic        stall;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] last_res = 64'd0;

    muldiv_unit_ctrl dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .result (result),
        .done   (done),
        .busy   (busy),
        .stall  (stall)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                p = 64'(sx * sy);
                return p;
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                return {x % y, x / y};
`else
                return 64'd0;
`endif
            end
        endcase
    endfunction

    // Posedges from driving req (in IDLE) to the first cycle with done high.
    function automatic int model_lat(input logic [1:0] o, input logic [31:0] y);
        if (!o[1]) return 34;
`ifdef MULDIV_DIV_EN
        if (y == 32'd0) return 2;
        return 34;
`else
        if (y == 32'd0) return 1;
        return 1;
`endif
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit keep_req,
                          input string tag, output time t_done);
        logic [63:0] exp;
        int elat, lat;
        bit seen;
        exp  = model(o, x, y);
        elat = model_lat(o, y);
        op = o; a = x; b = y; req = 1'b1;
        seen = 1'b0; lat = 0; t_done = 0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (k == 1) begin
                op = 2'($urandom); a = $urandom; b = $urandom;
            end
            if (done) begin
                seen = 1'b1; lat = k; t_done = $time;
            end else begin
                total++;
                if (stall !== 1'b1) begin
                    bad++;
                    $display("FAIL %s stall_wait k=%0d got=%b want=1", tag, k, stall);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout got=no_done want=done", tag);
        end else begin
            total++;
            if (lat !== elat) begin
                bad++;
                $display("FAIL %s latency got=%0d want=%0d", tag, lat, elat);
            end
            total++;
            if (result !== exp) begin
                bad++;
                $display("FAIL %s result got=%h want=%h", tag, result, exp);
            end
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL %s stall_done got=%b want=0", tag, stall);
            end
        end
        last_res = exp;
        if (!keep_req) req = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got=done%b,busy%b want=0,0", tag, done, busy);
        end
        if (keep_req) begin
            total++;
            if (stall !== 1'b1) begin
                bad++;
                $display("FAIL %s idle_stall got=%b want=1", tag, stall);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; flush = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0;
        #2;
        total++;
        if (result !== 64'd0 || done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset got=%h,%b,%b,%b want=0,0,0,0", result, done, busy, stall);
        end
        req = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_stall got=%b want=1", stall);
        end
        req = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_plan();
        time t;
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, "mul_s", t);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_u", t);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_s", t);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "div_u", t);
        run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, "div_zero", t);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf", t);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min", t);
    endtask

    task automatic test_random();
        time t;
        logic [1:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            run_op(o, x, y, 1'b0, "random", t);
        end
    endtask

    task automatic test_abort();
        time t;
        op = 2'b00; a = $urandom; b = $urandom; req = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL flush_run k=%0d got=%b,%b want=1,0", k, busy, done);
            end
        end
        flush = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        flush = 1'b0; req = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
            bad++;
            $display("FAIL flush_abort got=%b,%b,%h want=0,0,%h", busy, done, result, last_res);
        end
        run_op(2'b01, $urandom, $urandom, 1'b0, "after_flush", t);

        op = 2'b01; a = $urandom; b = $urandom; req = 1'b1;
        repeat (21) @(posedge sys_clk);
        @(negedge sys_clk);
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
                bad++;
                $display("FAIL req_drop k=%0d got=%b,%b,%h want=0,0,%h",
                         k, busy, done, result, last_res);
            end
        end
        run_op(2'b00, $urandom, $urandom, 1'b0, "after_drop", t);

        req = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(posedge sys_clk);
        @(negedge sys_clk);
        req = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        time t1, t2;
        run_op(2'b00, $urandom, $urandom, 1'b1, "b2b_first", t1);
        run_op(2'b01, $urandom, $urandom, 1'b0, "b2b_second", t2);
        total++;
        if ((t2 - t1) / 10 != 35) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=35", (t2 - t1) / 10);
        end
    endtask

    task automatic test_reset_mid();
        time t;
        run_op(2'b01, 32'd3, 32'd5, 1'b0, "pre_reset", t);
        op = 2'b00; a = $urandom; b = $urandom; req = 1'b1;
        repeat (15) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (result !== 64'd0 || done !== 1'b0 || busy !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got=%h,%b,%b,%b want=0,0,0,1", result, done, busy, stall);
        end
        req = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        run_op(2'b00, $urandom, $urandom, 1'b0, "post_reset", t);
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
